// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: CPU-side byte port of the PS/2 host transmitter.
// Ports: tx_data/tx_valid from the CPU; tx_ready/busy/tx_done/tx_err back to the CPU and receiver.
// master = CPU/MMIO side, slave = transmitter side.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, request-to-send, 11-clock frame, ack).
// Latency: INHIBIT_CYCLES + 1 cycles of clock inhibit, then 11 device clocks; tx_done/tx_err is a one-cycle pulse.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a frame is in flight.
// Ports: clk, clrn (async active-low); cpu (ps2_host_tx_if.slave): tx_data/tx_valid in,
//   tx_ready/busy/tx_done/tx_err out; ps2_clk_in/ps2_data_in raw pin levels; ps2_clk_oe/ps2_data_oe pull lines low.
// Optional: define PS2_TX_ACK_CHECK_EN to require the device ack (data low at the 11th clock fall).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk,
  input  logic         clrn,
  ps2_host_tx_if.slave cpu,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  // One counter serves both the inhibit interval and the inter-fall timeout.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [8:0]       r_shift, w_shift_nxt;
  logic [3:0]       r_bitcnt, w_bitcnt_nxt;
  logic             r_ack_ok, w_ack_ok_nxt;
  logic             r_clk_oe, w_clk_oe_nxt;
  logic             r_data_oe, w_data_oe_nxt;
  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_data_s1, r_data_s2;
  logic             w_fall, w_tmo, w_done, w_err;

  // Pin synchronizers; idle bus level is high, so reset to 1 to avoid a phantom fall.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= ps2_data_in;
      r_data_s2  <= r_data_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_tmo  = (r_cnt == TMO_LIMIT);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_ack_ok  <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_ack_ok  <= w_ack_ok_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
    end
  end

  // The oe registers are loaded with the level belonging to the next state,
  // so the pins change exactly with the state and never glitch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_bitcnt_nxt  = r_bitcnt;
    w_ack_ok_nxt  = r_ack_ok;
    w_clk_oe_nxt  = 1'b0;
    w_data_oe_nxt = 1'b0;
    w_done        = 1'b0;
    w_err         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (cpu.tx_valid) begin
          w_state_nxt  = S_INHIBIT;
          w_shift_nxt  = {~^cpu.tx_data, cpu.tx_data};
          w_bitcnt_nxt = '0;
          w_ack_ok_nxt = 1'b0;
          w_clk_oe_nxt = 1'b1;
        end
      end

      S_INHIBIT: begin
        w_clk_oe_nxt = 1'b1;
        if (r_cnt == INH_LAST) begin
          w_state_nxt   = S_REQ;
          w_cnt_nxt     = '0;
          w_data_oe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // One cycle with data already low and clock still held, then release clock.
      S_REQ: begin
        w_state_nxt   = S_SHIFT;
        w_cnt_nxt     = '0;
        w_bitcnt_nxt  = '0;
        w_data_oe_nxt = 1'b1;
      end

      S_SHIFT: begin
        w_data_oe_nxt = r_data_oe;
        if (w_tmo) begin
          w_err         = 1'b1;
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_data_oe_nxt = 1'b0;
        end else if (w_fall) begin
          w_cnt_nxt    = '0;
          w_bitcnt_nxt = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd9) begin
            // Tenth fall: release data for the stop bit.
            w_data_oe_nxt = 1'b0;
            w_state_nxt   = S_ACK;
          end else begin
            // Falls 1..9: d0..d7 then parity, LSB first out of the shifter.
            w_data_oe_nxt = ~r_shift[0];
            w_shift_nxt   = {1'b0, r_shift[8:1]};
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_ACK: begin
        if (w_tmo) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_fall) begin
          w_ack_ok_nxt = ~r_data_s2;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_WAIT_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        if (w_tmo) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_clk_s2 && r_data_s2) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          if (ACK_CHECK && !r_ack_ok) begin
            w_err = 1'b1;
          end else begin
            w_done = 1'b1;
          end
        end else if (w_fall) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign cpu.tx_ready = (r_state == S_IDLE);
  assign cpu.busy     = (r_state != S_IDLE);
  assign cpu.tx_done  = w_done;
  assign cpu.tx_err   = w_err;
  assign ps2_clk_oe   = r_clk_oe;
  assign ps2_data_oe  = r_data_oe;

endmodule
